// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// WIDTH-bit register with hold, shift left/right, rotate left/right, parallel
// load and clear. It tracks how many serial bits have been accepted since the
// last clear/reset, saturating at WIDTH. A parallel load counts as a full
// register.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset (beats enable and mode)
//   enable      in   0 = hold everything, whatever mode is
//   mode[2:0]   in   000 hold, 001 shr, 010 shl, 011 ror, 100 rol,
//                    101 load, 110 clear, 111 hold (reserved)
//   in          in   serial data input for the shift modes
//   load_data   in   parallel load value
//   out         out  register contents
//   serial_out  out  last bit shifted or rotated out (registered)
//   fill_count  out  serial bits accepted, saturating at WIDTH
//   full        out  fill_count == WIDTH (decoded straight from fill_count)
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out,
  output logic             serial_out,
  output logic [CW-1:0]    fill_count,
  output logic             full
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD  = 3'b111;

  localparam logic [CW-1:0] FILL_MAX = CW'(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("universal_shift_register: WIDTH must be in 2..32");
  end
  if ((2 ** CW) <= WIDTH) begin : g_bad_cw
    $error("universal_shift_register: CW too narrow to hold WIDTH");
  end

  logic [WIDTH-1:0] out_nxt;
  logic             serial_nxt;
  logic [CW-1:0]    fill_nxt;
  logic             shift_op;

  // Next-state selection; everything defaults to its current value so the
  // hold and reserved encodings need no explicit arm.
  always_comb begin
    out_nxt    = out;
    serial_nxt = serial_out;
    fill_nxt   = fill_count;
    shift_op   = 1'b0;

    case (mode)
      MODE_SHR: begin
        out_nxt    = {in, out[WIDTH-1:1]};
        serial_nxt = out[0];
        shift_op   = 1'b1;
      end
      MODE_SHL: begin
        out_nxt    = {out[WIDTH-2:0], in};
        serial_nxt = out[WIDTH-1];
        shift_op   = 1'b1;
      end
      MODE_ROR: begin
        out_nxt    = {out[0], out[WIDTH-1:1]};
        serial_nxt = out[0];
      end
      MODE_ROL: begin
        out_nxt    = {out[WIDTH-2:0], out[WIDTH-1]};
        serial_nxt = out[WIDTH-1];
      end
      MODE_LOAD: begin
        out_nxt  = load_data;
        fill_nxt = FILL_MAX;
      end
      MODE_CLEAR: begin
        out_nxt    = '0;
        serial_nxt = 1'b0;
        fill_nxt   = '0;
      end
      MODE_HOLD, MODE_RSVD: begin
      end
      default: begin
      end
    endcase

    // Serial shifts count up but never wrap past WIDTH.
    if (shift_op && (fill_count < FILL_MAX)) begin
      fill_nxt = fill_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= '0;
      serial_out <= 1'b0;
      fill_count <= '0;
    end else if (enable) begin
      out        <= out_nxt;
      serial_out <= serial_nxt;
      fill_count <= fill_nxt;
    end
  end

  assign full = (fill_count == FILL_MAX);

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [2:0]   mode;
  logic         sin;
  logic [W-1:0] load_data;
  logic [W-1:0] out;
  logic         serial_out;
  logic [CW-1:0] fill_count;
  logic         full;

  universal_shift_register #(.WIDTH(W), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .in         (sin),
    .load_data  (load_data),
    .out        (out),
    .serial_out (serial_out),
    .fill_count (fill_count),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: register value as a plain integer, updated with
  // arithmetic shifts and masks.
  typedef struct packed {
    logic [31:0] o;
    logic        s;
    logic [31:0] f;
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t model_next(input mdl_t c, input logic r, input logic e,
                                      input logic [2:0] md, input logic i,
                                      input logic [W-1:0] ld);
    mdl_t n;
    int unsigned mask, lsb, msb;
    n    = c;
    mask = (1 << W) - 1;
    lsb  = c.o & 1;
    msb  = (c.o >> (W - 1)) & 1;
    if (r) begin
      n = '0;
    end else if (e) begin
      case (md)
        3'd1: begin n.o = (c.o >> 1) | (32'(i) << (W - 1)); n.s = lsb[0]; n.f = (c.f < W) ? c.f + 1 : W; end
        3'd2: begin n.o = ((c.o << 1) | 32'(i)) & mask;     n.s = msb[0]; n.f = (c.f < W) ? c.f + 1 : W; end
        3'd3: begin n.o = (c.o >> 1) | (lsb << (W - 1));    n.s = lsb[0]; end
        3'd4: begin n.o = ((c.o << 1) | msb) & mask;        n.s = msb[0]; end
        3'd5: begin n.o = 32'(ld); n.f = W; end
        3'd6: begin n = '0; end
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, reset, enable, mode, sin, load_data);

  always @(negedge clk) begin
    if (checking) begin
      chk("out",        32'(out),        m.o);
      chk("serial_out", 32'(serial_out), 32'(m.s));
      chk("fill_count", 32'(fill_count), m.f);
      chk("full",       32'(full),       32'(m.f == W));
    end
  end

  // Apply one operation across exactly one rising edge; returns at the next
  // falling edge with outputs settled.
  task automatic op(input logic r, input logic e, input logic [2:0] md,
                    input logic i, input logic [W-1:0] ld);
    reset = r; enable = e; mode = md; sin = i; load_data = ld;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 3'd0; sin = 1'b0; load_data = '0;
    @(negedge clk);
    checking = 1'b1;
    chk("reset_out",  32'(out),        32'h0);
    chk("reset_ser",  32'(serial_out), 32'h0);
    chk("reset_fill", 32'(fill_count), 32'h0);
    chk("reset_full", 32'(full),       32'h0);

    // Shift right 1,0,1,0
    op(0, 1, 3'd1, 1, 8'h00); chk("shr1", 32'(out), 32'h80);
    op(0, 1, 3'd1, 0, 8'h00); chk("shr2", 32'(out), 32'h40);
    op(0, 1, 3'd1, 1, 8'h00); chk("shr3", 32'(out), 32'hA0);
    op(0, 1, 3'd1, 0, 8'h00); chk("shr4", 32'(out), 32'h50);
    chk("shr_fill4", 32'(fill_count), 32'd4);
    chk("shr_full0", 32'(full), 32'd0);

    // enable low with a shift mode: nothing moves
    for (int k = 0; k < 3; k++) op(0, 0, 3'd1, 1, 8'h00);
    chk("en0_out",  32'(out),        32'h50);
    chk("en0_ser",  32'(serial_out), 32'h0);
    chk("en0_fill", 32'(fill_count), 32'd4);

    // Saturation sequence
    op(1, 0, 3'd0, 0, 8'h00);
    begin
      logic [6:0] seq;
      seq = 7'b1101011;
      for (int k = 6; k >= 0; k--) op(0, 1, 3'd1, seq[k], 8'h00);
    end
    chk("sat_out7", 32'(out), 32'hD6);
    op(0, 1, 3'd1, 0, 8'h00);
    chk("sat_out8",  32'(out),        32'h6B);
    chk("sat_ser8",  32'(serial_out), 32'h0);
    chk("sat_full8", 32'(full),       32'h1);
    op(0, 1, 3'd1, 1, 8'h00);
    chk("sat_fill9", 32'(fill_count), 32'd8);

    // Load then rotate left twice
    op(0, 1, 3'd5, 0, 8'h93);
    op(0, 1, 3'd4, 0, 8'h00);
    chk("rol1_out", 32'(out), 32'h27); chk("rol1_ser", 32'(serial_out), 32'h1);
    op(0, 1, 3'd4, 1, 8'h00);
    chk("rol2_out", 32'(out), 32'h4E); chk("rol2_ser", 32'(serial_out), 32'h0);
    chk("rol_fill", 32'(fill_count), 32'd8);

    // Load, shift left, clear
    op(0, 1, 3'd5, 0, 8'h93);
    op(0, 1, 3'd2, 1, 8'h00);
    chk("shl_out", 32'(out), 32'h27); chk("shl_ser", 32'(serial_out), 32'h1);
    op(0, 1, 3'd6, 0, 8'h00);
    chk("clr_out",  32'(out),        32'h0);
    chk("clr_fill", 32'(fill_count), 32'h0);
    chk("clr_ser",  32'(serial_out), 32'h0);

    // Reset wins over a simultaneous load
    op(0, 1, 3'd5, 0, 8'h5A);
    op(1, 1, 3'd5, 0, 8'hFF);
    chk("rstld_out",  32'(out),        32'h0);
    chk("rstld_fill", 32'(fill_count), 32'h0);

    // Randomized traffic, checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      op(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8),
         3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
